// File: rtl/branch_pc_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_pc_ctl_if
//  Purpose  : Decode/CC inputs and fetch-PC outputs of the branch PC controller.
//  Revision : 1.0  initial release
// ============================================================================
interface branch_pc_ctl_if #(
    parameter int PC_WIDTH     = 16,
    parameter int OFFSET_WIDTH = 9
);
    logic                    instr_valid_in;
    logic                    is_br_in;
    logic [2:0]              nzp_dec_in;
    logic [OFFSET_WIDTH-1:0] offset_in;
    logic [PC_WIDTH-1:0]     br_pc_in;
    logic [2:0]              cc_in;
    logic                    cc_pending_in;
    logic                    fetch_ready_in;
    logic [PC_WIDTH-1:0]     pc_out;
    logic                    fetch_req_out;
    logic                    flush_out;
    logic                    taken_out;
    logic [1:0]              state_out;

    modport master (
        output instr_valid_in, is_br_in, nzp_dec_in, offset_in, br_pc_in,
               cc_in, cc_pending_in, fetch_ready_in,
        input  pc_out, fetch_req_out, flush_out, taken_out, state_out
    );

    modport slave (
        input  instr_valid_in, is_br_in, nzp_dec_in, offset_in, br_pc_in,
               cc_in, cc_pending_in, fetch_ready_in,
        output pc_out, fetch_req_out, flush_out, taken_out, state_out
    );
endinterface
`default_nettype wire

// File: rtl/branch_pc_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_pc_ctl
//  Purpose  : Branch resolution against N/Z/P condition state and fetch-PC
//             sequencing with redirect, CC-pending stall and fetch flush.
//  Revision : 1.0  initial release
// ============================================================================
module branch_pc_ctl #(
    parameter int                  PC_WIDTH     = 16,
    parameter int                  OFFSET_WIDTH = 9,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = 16'h3000,
    parameter int                  FLUSH_CYCLES = 2
) (
    input  wire logic          clka,
    input  wire logic          reset_in,
    branch_pc_ctl_if.slave     bus
);

    localparam int c_CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'b00,
        S_WAIT_CC = 2'b01,
        S_FLUSH   = 2'b10
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [PC_WIDTH-1:0]     r_pc, w_pc_nxt;
    logic                    r_flush, w_flush_nxt;
    logic                    r_taken, w_taken_nxt;
    logic [c_CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [2:0]              r_mask;
    logic [OFFSET_WIDTH-1:0] r_off;
    logic [PC_WIDTH-1:0]     r_brpc;
    logic                    w_latch;

    logic                    w_fetch_req;
    logic                    w_hs;
    logic [2:0]              w_mask;
    logic [OFFSET_WIDTH-1:0] w_off;
    logic [PC_WIDTH-1:0]     w_brpc;
    logic [PC_WIDTH-1:0]     w_target;
    logic                    w_is_taken;

    assign w_fetch_req = (r_state == S_RUN) && !reset_in;
    assign w_hs        = w_fetch_req && bus.fetch_ready_in;

    // While stalled the branch is resolved from the copy captured on entry.
    assign w_mask   = (r_state == S_WAIT_CC) ? r_mask : bus.nzp_dec_in;
    assign w_off    = (r_state == S_WAIT_CC) ? r_off  : bus.offset_in;
    assign w_brpc   = (r_state == S_WAIT_CC) ? r_brpc : bus.br_pc_in;
    assign w_target = w_brpc + {{(PC_WIDTH-OFFSET_WIDTH){w_off[OFFSET_WIDTH-1]}}, w_off};
    assign w_is_taken = (w_mask == 3'b111) || (|(w_mask & bus.cc_in));

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_flush_nxt = 1'b0;
        w_taken_nxt = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_hs) begin
                    w_pc_nxt = r_pc + PC_WIDTH'(1);
                end
                if (bus.instr_valid_in && bus.is_br_in) begin
                    if (bus.cc_pending_in) begin
                        w_state_nxt = S_WAIT_CC;
                        w_latch     = 1'b1;
                    end else if (w_is_taken) begin
                        w_state_nxt = S_FLUSH;
                        w_pc_nxt    = w_target;
                        w_flush_nxt = 1'b1;
                        w_taken_nxt = 1'b1;
                        w_cnt_nxt   = c_CNT_INIT;
                    end
                end
            end
            S_WAIT_CC: begin
                if (!bus.cc_pending_in) begin
                    if (w_is_taken) begin
                        w_state_nxt = S_FLUSH;
                        w_pc_nxt    = w_target;
                        w_flush_nxt = 1'b1;
                        w_taken_nxt = 1'b1;
                        w_cnt_nxt   = c_CNT_INIT;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_FLUSH: begin
                // r_cnt counts the FLUSH cycles still remaining after this one.
                if (r_cnt == '0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_flush_nxt = 1'b1;
                    w_cnt_nxt   = r_cnt - c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clka) begin
        if (reset_in) begin
            r_state <= S_RUN;
            r_pc    <= RESET_PC;
            r_flush <= 1'b0;
            r_taken <= 1'b0;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_off   <= '0;
            r_brpc  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_flush <= w_flush_nxt;
            r_taken <= w_taken_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_mask <= bus.nzp_dec_in;
                r_off  <= bus.offset_in;
                r_brpc <= bus.br_pc_in;
            end
        end
    end

    assign bus.pc_out        = r_pc;
    assign bus.fetch_req_out = w_fetch_req;
    assign bus.flush_out     = r_flush;
    assign bus.taken_out     = r_taken;
    assign bus.state_out     = r_state;

endmodule
`default_nettype wire
